gamepad_tx: RTL and testbench

//  Emulates the controller end of the SNES gamepad serial link. It answers console latch/clk strobes by

---
 rtl/gamepad_tx_if.sv | 32 +++
 rtl/gamepad_tx.sv | 153 +++++++++++++++
 tb/tb_gamepad_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gamepad_tx_if.sv
// gamepad_tx_if: console-port signal bundle for the SNES gamepad emulator.
//   master : console/driver side; drives buttons, turbo_mask and the latch/clk pins
//   slave  : gamepad_tx side; drives gamepad_data, frame_done and busy
// Signals:
//   buttons[NUM_BITS]     1 = pressed, bit0 (B) goes out first
//   turbo_mask[NUM_BITS]  1 = autofire on that button
//   gamepad_latch         console latch pin, active high, async to clk
//   gamepad_clk           console clock pin, idle high, async to clk
//   gamepad_data          serial data toward the console, low = pressed
//   frame_done            one-cycle pulse after the last bit of a frame
//   busy                  high while a frame is being loaded or shifted
interface gamepad_tx_if #(
    parameter int NUM_BITS = 16
) ();
    logic [NUM_BITS-1:0] buttons;
    logic [NUM_BITS-1:0] turbo_mask;
    logic                gamepad_latch;
    logic                gamepad_clk;
    logic                gamepad_data;
    logic                frame_done;
    logic                busy;

    modport master (
        output buttons, turbo_mask, gamepad_latch, gamepad_clk,
        input  gamepad_data, frame_done, busy
    );

    modport slave (
        input  buttons, turbo_mask, gamepad_latch, gamepad_clk,
        output gamepad_data, frame_done, busy
    );
endinterface

// File: rtl/gamepad_tx.sv
// gamepad_tx: controller end of the SNES gamepad serial link. The latch and clock
// pins are synchronized into clk, and each frame shifts the inverted button word
// out LSB first on gamepad_data.
// Ports:
//   clk   system clock (>= 8 MHz)
//   rst   synchronous, active-high reset
//   bus   gamepad_tx_if.slave (buttons, turbo_mask, latch/clk pins, data, frame_done, busy)
// Optional feature: define GAMEPAD_TX_TURBO_EN to enable autofire on the buttons
// selected by turbo_mask, toggling every TURBO_PERIOD latches.
//
// state | meaning
// IDLE  | no latch seen since reset, data held high
// LOAD  | latch high, shift register tracks the button word
// SHIFT | shifting one bit per console clk rising edge
// DONE  | all bits sent, data held at FILL_LEVEL until the next latch
module gamepad_tx #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   NUM_BITS     = 16,
    parameter logic FILL_LEVEL   = 1'b0,
    parameter int   TURBO_PERIOD = 4
) (
    input  logic         clk,
    input  logic         rst,
    gamepad_tx_if.slave  bus
);
    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
    logic                latch_d, clk_d;
    logic                latch_s, clk_s, latch_fall, clk_rise;
    logic [NUM_BITS-1:0] eff_buttons, wire_word;
    logic [NUM_BITS-1:0] sreg, sreg_nxt, sreg_shift;
    logic [CW-1:0]       bit_cnt, cnt_nxt, cnt_inc;
    logic                data_q, data_nxt;
    logic                done_q, done_nxt;

    // An extra flop after the last sync stage gives a clean edge compare and
    // keeps pin-to-data latency at SYNC_STAGES+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_sync <= '0;
            clk_sync   <= '1;
            latch_d    <= 1'b0;
            clk_d      <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.gamepad_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.gamepad_clk};
            latch_d    <= latch_sync[SYNC_STAGES-1];
            clk_d      <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_fall = latch_d & ~latch_s;
    assign clk_rise   = clk_s & ~clk_d;

`ifdef GAMEPAD_TX_TURBO_EN
    logic [7:0] turbo_cnt;
    logic       turbo_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_cnt   <= 8'd0;
            turbo_phase <= 1'b0;
        end else if (latch_fall) begin
            if (turbo_cnt == 8'(TURBO_PERIOD - 1)) begin
                turbo_cnt   <= 8'd0;
                turbo_phase <= ~turbo_phase;
            end else begin
                turbo_cnt <= turbo_cnt + 8'd1;
            end
        end
    end

    // Phase 0 forces masked buttons released, so autofire starts released.
    assign eff_buttons = bus.buttons & ~(bus.turbo_mask & {NUM_BITS{~turbo_phase}});
`else
    assign eff_buttons = bus.buttons;
`endif

    assign wire_word = ~eff_buttons;
    assign cnt_inc   = bit_cnt + CW'(1);

    always_comb begin
        sreg_shift               = sreg >> 1;
        sreg_shift[NUM_BITS-1]   = FILL_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '1;
            bit_cnt <= '0;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            bit_cnt <= cnt_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = bit_cnt;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                data_nxt = 1'b1;
                if (latch_s) state_nxt = LOAD;
            end
            LOAD: begin
                sreg_nxt = wire_word;
                data_nxt = wire_word[0];
                cnt_nxt  = '0;
                if (latch_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                // Latch wins over a coincident clk edge and aborts the frame.
                if (latch_s) begin
                    state_nxt = LOAD;
                end else if (clk_rise) begin
                    sreg_nxt = sreg_shift;
                    cnt_nxt  = cnt_inc;
                    if (cnt_inc == CW'(NUM_BITS)) begin
                        data_nxt  = FILL_LEVEL;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        data_nxt = sreg_shift[0];
                    end
                end
            end
            DONE: begin
                data_nxt = FILL_LEVEL;
                if (latch_s) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.gamepad_data = data_q;
    assign bus.frame_done   = done_q;
    assign bus.busy         = (state == LOAD) || (state == SHIFT);
endmodule

// File: tb/tb_gamepad_tx.sv
`timescale 1ns/1ps
module tb_gamepad_tx;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    gamepad_tx_if #(.NUM_BITS(NB)) bus ();

    gamepad_tx #(
        .SYNC_STAGES(2), .NUM_BITS(NB), .FILL_LEVEL(1'b0), .TURBO_PERIOD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #50 clk = ~clk;

    always @(posedge clk) if (bus.frame_done === 1'b1) done_cnt = done_cnt + 1;

    initial begin
        #10_000_000;
        $display("FAIL timeout: got no finish, expected finish before 10ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic latch_pulse();
        bus.gamepad_latch = 1'b1;
        #12000;
        bus.gamepad_latch = 1'b0;
    endtask

    task automatic clk_pulse();
        bus.gamepad_clk = 1'b0;
        #6000;
        bus.gamepad_clk = 1'b1;
        #6000;
    endtask

    // bits[0] is sampled after the latch falls, bits[i] after the i-th rising edge.
    task automatic run_frame(input int npulses, output logic [31:0] bits);
        bits = '0;
        latch_pulse();
        #3000;
        bits[0] = bus.gamepad_data;
        for (int i = 1; i <= npulses; i++) begin
            clk_pulse();
            bits[i] = bus.gamepad_data;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] bits;
    logic [7:0]  t4;

    initial begin
        bus.buttons       = '0;
        bus.turbo_mask    = '0;
        bus.gamepad_latch = 1'b0;
        bus.gamepad_clk   = 1'b1;
        do_reset();
        check("reset_data", 32'(bus.gamepad_data), 32'h1);
        check("reset_done", 32'(bus.frame_done), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);

        // single pressed B button
        bus.buttons = 16'h0001;
        done_cnt = 0;
        run_frame(16, bits);
        check("b_bit0", 32'(bits[0]), 32'h0);
        check("b_bits1_15", 32'(bits[15:1]), 32'h7FFF);
        check("b_fill", 32'(bits[16]), 32'h0);
        check("b_done_cnt", 32'(done_cnt), 32'h1);
        check("b_busy_done", 32'(bus.busy), 32'h0);

        // pattern
        bus.buttons = 16'hA5C3;
        run_frame(16, bits);
        check("pattern_word", 32'(bits[15:0]), 32'h5A3C);

        // overrun: extra clocks are ignored after the frame
        bus.buttons = 16'h00FF;
        done_cnt = 0;
        run_frame(20, bits);
        check("overrun_word", 32'(bits[15:0]), 32'hFF00);
        check("overrun_fill", 32'(bits[20:16]), 32'h0);
        check("overrun_done_cnt", 32'(done_cnt), 32'h1);

        // abort mid-frame with a new latch
        bus.buttons = 16'hFFFF;
        done_cnt = 0;
        run_frame(5, bits);
        check("abort_pre_bits", 32'(bits[5:0]), 32'h0);
        bus.buttons = 16'h0002;
        bus.gamepad_latch = 1'b1;
        #12000;
        check("abort_busy", 32'(bus.busy), 32'h1);
        check("abort_no_done", 32'(done_cnt), 32'h0);
        bus.gamepad_latch = 1'b0;
        #3000;
        bits = '0;
        bits[0] = bus.gamepad_data;
        for (int i = 1; i <= 16; i++) begin
            clk_pulse();
            bits[i] = bus.gamepad_data;
        end
        check("abort_first4", 32'(bits[3:0]), 32'hD);
        check("abort_word", 32'(bits[15:0]), 32'hFFFD);
        check("abort_done_cnt", 32'(done_cnt), 32'h1);

        // reset mid-frame, then clocks without a latch do nothing
        bus.buttons = 16'hFFFF;
        done_cnt = 0;
        run_frame(3, bits);
        check("midrst_pre_busy", 32'(bus.busy), 32'h1);
        do_reset();
        check("midrst_data", 32'(bus.gamepad_data), 32'h1);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 3; i++) clk_pulse();
        check("midrst_idle_data", 32'(bus.gamepad_data), 32'h1);
        check("midrst_no_done", 32'(done_cnt), 32'h0);

        // turbo on bit4
        do_reset();
        bus.buttons    = 16'h0010;
        bus.turbo_mask = 16'h0010;
        t4 = '0;
        for (int f = 0; f < 8; f++) begin
            run_frame(16, bits);
            t4[f] = bits[4];
        end
`ifdef GAMEPAD_TX_TURBO_EN
        check("turbo_bit4", 32'(t4), 32'h33);
`else
        check("turbo_bit4", 32'(t4), 32'h00);
`endif
        check("turbo_other_bits", 32'(bits[15:5]), 32'h7FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
